// File: rtl/sw_input_port_pkg.sv
// Shared definitions for the operator input path.
// Holds the data width default, synchroniser depth and debounce state codes.
package sw_input_port_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int SYNC_DEPTH = 2;

  typedef logic [1:0] db_state_t;

  localparam db_state_t REL     = 2'd0;
  localparam db_state_t CHK_PRS = 2'd1;
  localparam db_state_t PRS     = 2'd2;
  localparam db_state_t CHK_REL = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and debounce FSM, reusable for any active-low button.
// Ports: clk, rst_n, btn_raw (0=pressed) -> level (1=released), press pulse.
module btn_debounce
  import sw_input_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [SYNC_DEPTH-1:0] sync;
  logic                  synced;
  db_state_t             state;
  logic [CNT_W-1:0]      cnt;

  assign synced = sync[SYNC_DEPTH-1];

  // Level stays "pressed" until a release is confirmed.
  assign level = ~((state == PRS) | (state == CHK_REL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '1;
      state <= REL;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_DEPTH-2:0], btn_raw};
      press <= 1'b0;
      unique case (state)
        REL: begin
          if (!synced) begin
            state <= CHK_PRS;
            cnt   <= ONE;
          end
        end
        CHK_PRS: begin
          if (synced) begin
            state <= REL;
            cnt   <= '0;
          end else if (cnt == LIMIT) begin
            state <= PRS;
            press <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        PRS: begin
          if (synced) begin
            state <= CHK_REL;
            cnt   <= ONE;
          end
        end
        CHK_REL: begin
          if (!synced) begin
            state <= PRS;
          end else if (cnt == LIMIT) begin
            state <= REL;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= REL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sw_input_port.sv
// Operator-to-CPU input path: debounced enter button latches switches.
// Ports: CLK1, RST_N, BTN_RAW, SW_RAW, IN_ACK, CLR_OVR -> IN_DATA, IN_VALID, OVERRUN, PRESS_CNT.
module sw_input_port
  import sw_input_port_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic              CLK1,
  input  logic              RST_N,
  input  logic              BTN_RAW,
  input  logic [DATA_W-1:0] SW_RAW,
  output logic [DATA_W-1:0] IN_DATA,
  output logic              IN_VALID,
  input  logic              IN_ACK,
  input  logic              CLR_OVR,
  output logic              OVERRUN,
  output logic [3:0]        PRESS_CNT
);

  logic                               btn_level;
  logic                               press;
  logic [SYNC_DEPTH-1:0][DATA_W-1:0]  sw_sync;
  logic [DATA_W-1:0]                  sw_s;
  logic                               take;
  logic                               accept;
  logic                               drop;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db (
    .clk    (CLK1),
    .rst_n  (RST_N),
    .btn_raw(BTN_RAW),
    .level  (btn_level),
    .press  (press)
  );

  assign sw_s = sw_sync[SYNC_DEPTH-1];

  // An ack in the pulse cycle frees the slot for the new value.
  assign take   = press & ~btn_level;
  assign accept = take & (~IN_VALID | IN_ACK);
  assign drop   = take & IN_VALID & ~IN_ACK;

  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      sw_sync   <= '0;
      IN_DATA   <= '0;
      IN_VALID  <= 1'b0;
      OVERRUN   <= 1'b0;
      PRESS_CNT <= 4'd0;
    end else begin
      sw_sync <= {sw_sync[SYNC_DEPTH-2:0], SW_RAW};
      if (accept) begin
        IN_DATA   <= sw_s;
        IN_VALID  <= 1'b1;
        PRESS_CNT <= PRESS_CNT + 4'd1;
      end else if (IN_ACK && IN_VALID) begin
        IN_VALID <= 1'b0;
      end
      if (drop) begin
        OVERRUN <= 1'b1;
      end else if (CLR_OVR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sw_input_port.md
Name: sw_input_port

Overview:
- Operator-to-CPU input path of the board top level; the counterpart of the result-to-display output path.
- Synchronises and debounces the enter push button (active-low on the board) and synchronises the 4-bit data switches.
- On each debounced press, latches the switch value into a holding register and presents it to the CPU with a valid/ack handshake.
- Flags an overrun when a press arrives while data is still unconsumed, and counts accepted presses for LED display.

Parameters:
- DATA_W, 4, width of switch data and of IN_DATA.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz); minimum legal value 1.
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK1  in  1  system clock, 50 MHz board clock.
- RST_N  in  1  asynchronous active-low reset.
- BTN_RAW  in  1  raw enter button, 0 = pressed, asynchronous, bouncy.
- SW_RAW  in  DATA_W  raw data switches, asynchronous.
- IN_DATA  out  DATA_W  latched switch value offered to CPU.
- IN_VALID  out  1  IN_DATA holds an unconsumed value.
- IN_ACK  in  1  CPU consumes IN_DATA; meaningful only while IN_VALID=1.
- CLR_OVR  in  1  synchronous clear of OVERRUN.
- OVERRUN  out  1  sticky: a press was dropped because IN_VALID was still 1.
- PRESS_CNT  out  4  count of accepted presses, wraps 15→0.

Behaviour:
- Reset (RST_N=0, asynchronous, any cycle):
  - Both synchroniser chains load: button chain 1, switch chain 0.
  - Debounced level = 1 (released); debounce counter = 0.
  - IN_DATA=0, IN_VALID=0, OVERRUN=0, PRESS_CNT=0.
  - Any in-flight debounce or held data is discarded.
- Synchronisation: 2-flop synchroniser on BTN_RAW and on each SW_RAW bit. The switch bits are not debounced and are sampled only at the capture edge.
- Debounce FSM (states REL, CHK_PRS, PRS, CHK_REL):
  - REL: synced=0 → CHK_PRS, counter cleared to 1.
  - CHK_PRS:
    - synced=1 → REL, counter cleared to 0.
    - Counter reaches DEBOUNCE_CYCLES → PRS and assert a 1-cycle press pulse.
    - Otherwise increment the counter.
  - PRS: synced=1 → CHK_REL, counter cleared to 1.
  - CHK_REL: synced=0 → PRS; counter reaches DEBOUNCE_CYCLES → REL (no pulse); otherwise increment.
  - Only the press transition produces a pulse; release produces none.
- Latency: with BTN_RAW held low from edge 0, the press pulse occurs at edge 2+DEBOUNCE_CYCLES and IN_VALID rises at edge 3+DEBOUNCE_CYCLES.
- Capture, on the press pulse:
  - IN_VALID=0 → IN_DATA ← synced switches, IN_VALID←1, PRESS_CNT+1.
  - IN_VALID=1 and IN_ACK=1 in the same cycle → old value consumed, new value captured, IN_VALID stays 1, PRESS_CNT+1, no overrun.
  - IN_VALID=1 and IN_ACK=0 → new value dropped, IN_DATA unchanged, OVERRUN←1, PRESS_CNT unchanged.
- Handshake:
  - IN_ACK with IN_VALID=1 and no press pulse → IN_VALID←0 next edge. IN_DATA keeps its value, which is don't-care while IN_VALID=0.
  - IN_ACK while IN_VALID=0 is ignored.
- OVERRUN: cleared by CLR_OVR. If CLR_OVR and a set condition occur in the same cycle, set wins.
- All outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Shared package holds DATA_W default, the debounce state typedef (REL, CHK_PRS, PRS, CHK_REL) and the 2-flop synchroniser depth constant.
- Sub-module btn_debounce: button synchroniser plus debounce FSM and counter, producing the debounced level and press pulse. It is reusable for other board buttons.
- sw_input_port instantiates btn_debounce and contains the switch synchroniser, capture register, handshake, overrun and counter logic.

Test Plan (sim with DEBOUNCE_CYCLES=4):
- Clean press: SW_RAW=0xA, BTN_RAW 1→0 at edge 0 and held → IN_VALID=1 at edge 7, IN_DATA=0xA, PRESS_CNT=1; IN_ACK one cycle → IN_VALID=0 next edge.
- Bounce: BTN_RAW toggles 0/1 every 2 cycles for 20 cycles, then held 0 → exactly one capture, PRESS_CNT=1; a 3-cycle release glitch during the hold gives no second capture.
- Overrun: capture 0x3, no ack, release, then press with SW=0x5 → IN_DATA=0x3, OVERRUN=1, PRESS_CNT=1; CLR_OVR → OVERRUN=0.
- Simultaneous: IN_VALID=1 (0x3), IN_ACK asserted in the press-pulse cycle with SW=0xC → IN_DATA=0xC, IN_VALID stays 1, OVERRUN=0, PRESS_CNT=2.
- Reset mid-debounce: RST_N low at counter=2 with button held → all outputs 0 at once; after release of reset, a full 4 stable cycles are again required before capture.
- Wrap: 16 acked presses → PRESS_CNT returns to 0 with no OVERRUN.
